// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencer for the E-stage multiply/divide unit.
//
// The full 64-bit result is computed combinationally from a/b and captured
// into temp_hi/temp_lo on the issue edge; a busy down-counter then models the
// unit's latency. HI/LO are only written on the terminal-count edge, so they
// always show committed values.
//
// Ports:
//   clk      in   pipeline clock, rising edge
//   reset    in   asynchronous, active-low reset
//   start    in   E-stage MDU op valid this cycle
//   op       in   [2:0] 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 no-op
//   a, b     in   [31:0] rs / rt operands
//   d_is_md  in   D-stage instruction is MULT/DIV/MF*/MT*
//   cancel   in   abort in-flight op (only with MDU_CANCEL_EN)
//   busy     out  arithmetic op in flight
//   stall    out  freeze request to D/E registers (combinational)
//   done     out  one-cycle pulse after HI/LO commit
//   hi, lo   out  [31:0] committed HI/LO registers
//
// Optional feature macro: MDU_CANCEL_EN (cancel aborts or suppresses an op).
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no arithmetic op in flight, accepts start
// MUL   | MULT/MULTU in flight, cnt counts down to commit
// DIV   | DIV/DIVU in flight, cnt counts down to commit

module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    input  logic        cancel,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] temp_hi;
    logic [31:0] temp_lo;
    logic        skip_commit;
    logic        cancel_eff;

`ifdef MDU_CANCEL_EN
    assign cancel_eff = cancel;
`else
    assign cancel_eff = cancel & 1'b0;
`endif

    // Arithmetic datapath. The divisor is forced to 1 when b==0 so the
    // dividers never see a zero; that result is discarded via skip_commit.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_b;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign div_b  = (b == 32'd0) ? 32'd1 : b;
    assign quot_s = $signed(a) / $signed(div_b);
    assign rem_s  = $signed(a) % $signed(div_b);
    assign quot_u = a / div_b;
    assign rem_u  = a % div_b;

    assign busy  = (state != IDLE);
    assign stall = d_is_md & (busy | (start & (op <= 3'd3)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            temp_hi     <= 32'd0;
            temp_lo     <= 32'd0;
            skip_commit <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel_eff) begin
                        case (op)
                            3'd0: begin
                                {temp_hi, temp_lo} <= prod_s;
                                skip_commit        <= 1'b0;
                                cnt                <= MUL_LOAD;
                                state              <= MUL;
                            end
                            3'd1: begin
                                {temp_hi, temp_lo} <= prod_u;
                                skip_commit        <= 1'b0;
                                cnt                <= MUL_LOAD;
                                state              <= MUL;
                            end
                            3'd2: begin
                                temp_hi     <= rem_s;
                                temp_lo     <= quot_s;
                                skip_commit <= (b == 32'd0);
                                cnt         <= DIV_LOAD;
                                state       <= DIV;
                            end
                            3'd3: begin
                                temp_hi     <= rem_u;
                                temp_lo     <= quot_u;
                                skip_commit <= (b == 32'd0);
                                cnt         <= DIV_LOAD;
                                state       <= DIV;
                            end
                            3'd4: hi <= a;
                            3'd5: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    // cancel outranks the terminal-count commit
                    if (cancel_eff) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        if (!skip_commit) begin
                            hi <= temp_hi;
                            lo <= temp_lo;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;
`ifdef MDU_CANCEL_EN
    localparam bit CANCEL_ON = 1'b1;
`else
    localparam bit CANCEL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        d_is_md = 1'b0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .d_is_md(d_is_md), .cancel(cancel), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: remaining busy cycles plus a pending 64-bit result
    // computed with plain integer arithmetic.
    int          m_rem = 0;
    bit          m_done = 1'b0;
    bit          m_skip = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;

    always @(posedge clk or negedge reset) begin
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        if (!reset) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                if (CANCEL_ON && cancel) begin
                    m_rem = 0;
                end else begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_done = 1'b1;
                        if (!m_skip) begin
                            m_hi = p_hi;
                            m_lo = p_lo;
                        end
                    end
                end
            end else if (start && !(CANCEL_ON && cancel)) begin
                sa = $signed(a);
                sb = $signed(b);
                ua = a;
                ub = b;
                m_skip = 1'b0;
                if (op == 3'd0) begin
                    sq = sa * sb;
                    {p_hi, p_lo} = sq;
                    m_rem = MUL_N;
                end else if (op == 3'd1) begin
                    ua = ua * ub;
                    {p_hi, p_lo} = ua;
                    m_rem = MUL_N;
                end else if (op == 3'd2 || op == 3'd3) begin
                    m_rem = DIV_N;
                    if (b == 32'd0) begin
                        m_skip = 1'b1;
                    end else if (op == 3'd2) begin
                        sq = sa / sb;
                        sr = sa - sq * sb;
                        p_lo = sq[31:0];
                        p_hi = sr[31:0];
                    end else begin
                        p_lo = 32'(ua / ub);
                        p_hi = 32'(ua % ub);
                    end
                end else if (op == 3'd4) begin
                    m_hi = a;
                end else if (op == 3'd5) begin
                    m_lo = a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy", 64'(busy), 64'(m_rem > 0));
            chk("cyc done", 64'(done), 64'(m_done));
            chk("cyc hi", 64'(hi), 64'(m_hi));
            chk("cyc lo", 64'(lo), 64'(m_lo));
            chk("cyc stall", 64'(stall),
                64'(d_is_md & ((m_rem > 0) | (start & (op <= 3'd3)))));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        start = 1'b1; op = o; a = aa; b = bb;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk({nm, " busy_cycles"}, 64'(n), 64'(cyc));
        chk({nm, " done_pulse"}, 64'(done), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(ehi));
        chk({nm, " lo"}, 64'(lo), 64'(elo));
        tick();
        chk({nm, " done_low"}, 64'(done), 64'd0);
    endtask

    task automatic write_hl(input logic [2:0] o, input logic [31:0] v);
        start = 1'b1; op = o; a = v; b = 32'd0;
        tick();
        start = 1'b0;
        chk("mt busy", 64'(busy), 64'd0);
        chk("mt done", 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        tick();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        reset = 1'b1;
        tick();
        chk_en = 1'b1;

        run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_100d7", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        write_hl(3'd4, 32'h12);
        chk("mthi hi", 64'(hi), 64'h12);
        write_hl(3'd5, 32'h34);
        chk("mtlo lo", 64'(lo), 64'h34);
        run_op("divu_by0", 3'd3, 32'h10, 32'd0, 10, 32'h12, 32'h34);

        // undefined op: nothing changes
        start = 1'b1; op = 3'd6; a = 32'hDEAD; b = 32'd1;
        tick();
        start = 1'b0;
        chk("op6 busy", 64'(busy), 64'd0);
        chk("op6 hi", 64'(hi), 64'h12);
        chk("op6 lo", 64'(lo), 64'h34);

        // stall with MULTU, plus an ignored second start mid-busy
        d_is_md = 1'b1;
        start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        #1;
        chk("stall issue", 64'(stall), 64'd1);
        chk("stall issue busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            chk("stall busy", 64'(stall), 64'd1);
            if (n == 2) begin
                start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd100;
                tick();
                start = 1'b0;
                n++;
                chk("stall busy2", 64'(stall), 64'd1);
            end
            tick();
        end
        chk("multu busy_cycles", 64'(n), 64'd5);
        chk("stall after", 64'(stall), 64'd0);
        chk("multu hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu lo", 64'(lo), 64'h1);
        tick();
        chk("multu no second op", 64'(busy), 64'd0);
        d_is_md = 1'b0;

        // cancel at busy cycle 3 of MULT 3*4
        write_hl(3'd5, 32'h55);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`ifdef MDU_CANCEL_EN
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel done", 64'(done), 64'd0);
        chk("cancel lo", 64'(lo), 64'h55);
        tick();
        chk("cancel done2", 64'(done), 64'd0);
        chk("cancel lo2", 64'(lo), 64'h55);
`else
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("nocancel remaining", 64'(n), 64'd2);
        chk("nocancel done", 64'(done), 64'd1);
        chk("nocancel lo", 64'(lo), 64'd12);
        tick();
`endif

        // reset in the middle of a DIV, at cnt==4 (sixth busy cycle)
        write_hl(3'd4, 32'h77);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        chk("async rst hi", 64'(hi), 64'd0);
        chk("async rst lo", 64'(lo), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("post-rst busy", 64'(busy), 64'd0);
        chk("post-rst hi", 64'(hi), 64'd0);
        chk("post-rst lo", 64'(lo), 64'd0);

        run_op("mult_after_rst", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
